// File: rtl/mult_arbiter_pkg.sv
// Shared types and widths for the two-requester multiplier arbiter.
// CALC2 is only entered when MULT_ARB_PIPE_EN is defined.
package mult_arbiter_pkg;

  localparam int OP_W   = 4;
  localparam int PROD_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    CALC2 = 2'd2,
    RESP  = 2'd3
  } state_e;

endpackage

// File: rtl/mult_arbiter_mult4x4_core.sv
// Combinational 4x4 unsigned multiplier with full 8-bit product.
module mult4x4_core
  import mult_arbiter_pkg::*;
(
  input  logic [OP_W-1:0]   m,
  input  logic [OP_W-1:0]   q,
  output logic [PROD_W-1:0] p
);

  assign p = PROD_W'(m) * PROD_W'(q);

endmodule

// File: rtl/mult_arbiter.sv
// Round-robin arbiter sharing one 4x4 multiplier between two requesters.
// Define MULT_ARB_PIPE_EN to add a product register stage (CALC2).
//
// state | meaning
// IDLE  | waiting for a request; grants combinationally and captures operands
// CALC  | multiplies captured operands (loads result, or pipe stage if enabled)
// CALC2 | moves pipe stage into result register (MULT_ARB_PIPE_EN only)
// RESP  | result valid, held until rsp_ready
module mult_arbiter
  import mult_arbiter_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [OP_W-1:0]   req_m0,
  input  logic [OP_W-1:0]   req_q0,
  input  logic [OP_W-1:0]   req_m1,
  input  logic [OP_W-1:0]   req_q1,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [PROD_W-1:0] rsp_p,
  output logic              busy,
  output logic [CNT_W-1:0]  op_count
);

  state_e              state_q;
  logic                ptr_q;
  logic [OP_W-1:0]     m_q;
  logic [OP_W-1:0]     q_q;
  logic                id_q;
  logic [PROD_W-1:0]   rsp_p_q;
  logic                rsp_id_q;
  logic [CNT_W-1:0]    op_count_q;
  logic [PROD_W-1:0]   product;
  logic                grant_any;
  logic                grant_id;
`ifdef MULT_ARB_PIPE_EN
  logic [PROD_W-1:0]   pipe_q;
`endif

  mult4x4_core u_core (
    .m (m_q),
    .q (q_q),
    .p (product)
  );

  // A lone requester always wins; the pointer only breaks ties.
  always_comb begin
    grant_any = |req_valid;
    grant_id  = 1'b0;
    if (req_valid == 2'b10)      grant_id = 1'b1;
    else if (req_valid == 2'b11) grant_id = ptr_q;
  end

  assign req_ready = (state_q == IDLE && grant_any) ? (2'b01 << grant_id) : 2'b00;
  assign rsp_valid = (state_q == RESP);
  assign busy      = (state_q != IDLE);
  assign rsp_p     = rsp_p_q;
  assign rsp_id    = rsp_id_q;
  assign op_count  = op_count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ptr_q      <= 1'b0;
      m_q        <= '0;
      q_q        <= '0;
      id_q       <= 1'b0;
      rsp_p_q    <= '0;
      rsp_id_q   <= 1'b0;
      op_count_q <= '0;
`ifdef MULT_ARB_PIPE_EN
      pipe_q     <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_any) begin
            m_q     <= grant_id ? req_m1 : req_m0;
            q_q     <= grant_id ? req_q1 : req_q0;
            id_q    <= grant_id;
            ptr_q   <= ~grant_id;
            state_q <= CALC;
          end
        end
        CALC: begin
          rsp_id_q <= id_q;
`ifdef MULT_ARB_PIPE_EN
          pipe_q   <= product;
          state_q  <= CALC2;
`else
          rsp_p_q  <= product;
          state_q  <= RESP;
`endif
        end
`ifdef MULT_ARB_PIPE_EN
        CALC2: begin
          rsp_p_q <= pipe_q;
          state_q <= RESP;
        end
`endif
        RESP: begin
          if (rsp_ready) begin
            op_count_q <= op_count_q + CNT_W'(1);
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_arbiter.sv
// Scoreboard bench for mult_arbiter; expected responses queued at grant,
// popped by a negedge monitor on each accepted response.
module tb_mult_arbiter;

  localparam int CNT_W = 2;
`ifdef MULT_ARB_PIPE_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [1:0]       req_valid = 2'b00;
  logic [1:0]       req_ready;
  logic [3:0]       req_m0 = '0, req_q0 = '0, req_m1 = '0, req_q1 = '0;
  logic             rsp_valid;
  logic             rsp_ready = 1'b0;
  logic             rsp_id;
  logic [7:0]       rsp_p;
  logic             busy;
  logic [CNT_W-1:0] op_count;

  int               checks = 0;
  int               errors = 0;
  logic [8:0]       sb_q[$];
  logic [8:0]       sb_e;
  logic [CNT_W-1:0] exp_cnt = '0;
  int               seq[5] = '{1, 2, 3, 0, 1};

  mult_arbiter #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_m0    (req_m0),
    .req_q0    (req_q0),
    .req_m1    (req_m1),
    .req_q1    (req_q1),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_p     (rsp_p),
    .busy      (busy),
    .op_count  (op_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_cnt = '0;
    end else if (rsp_valid && rsp_ready) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_rsp", 1, 0);
      end else begin
        sb_e = sb_q.pop_front();
        chk("rsp_id", int'(rsp_id), int'(sb_e[8]));
        chk("rsp_p", int'(rsp_p), int'(sb_e[7:0]));
      end
      chk("op_count_at_accept", int'(op_count), int'(exp_cnt));
      exp_cnt = exp_cnt + 1'b1;
    end
  end

  task automatic wait_rsp();
    int cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 1) chk("req_ready_low_after_grant", int'(req_ready), 0);
    end while (!rsp_valid && cyc < 10);
    chk("grant_to_valid_latency", cyc, LAT);
  endtask

  // Issue one request with rsp_ready already high; returns in IDLE after accept.
  task automatic run_op(input logic [1:0] v, input logic [1:0] g,
                        input logic id, input logic [7:0] p);
    req_valid = v;
    #1;
    chk("grant", int'(req_ready), int'(g));
    sb_q.push_back({id, p});
    wait_rsp();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = 2'b00;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #3;
    chk("rst_req_ready", int'(req_ready), 0);
    chk("rst_rsp_valid", int'(rsp_valid), 0);
    chk("rst_rsp_p", int'(rsp_p), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_op_count", int'(op_count), 0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    // Single requester 0, 3*5
    rsp_ready = 1'b1;
    req_m0 = 4'd3; req_q0 = 4'd5;
    run_op(2'b01, 2'b01, 1'b0, 8'd15);
    req_valid = 2'b00;
    chk("op_count_after_first", int'(op_count), 1);

    // Both valid from reset: alternate 0,1,0,1
    do_reset();
    req_m0 = 4'd15; req_q0 = 4'd15; req_m1 = 4'd2; req_q1 = 4'd7;
    run_op(2'b11, 2'b01, 1'b0, 8'd225);
    run_op(2'b11, 2'b10, 1'b1, 8'd14);
    run_op(2'b11, 2'b01, 1'b0, 8'd225);
    run_op(2'b11, 2'b10, 1'b1, 8'd14);
    run_op(2'b10, 2'b10, 1'b1, 8'd14);
    run_op(2'b01, 2'b01, 1'b0, 8'd225);

    // Backpressure: hold result 5 cycles with both requesting
    rsp_ready = 1'b0;
    req_m1 = 4'd6; req_q1 = 4'd11;
    req_valid = 2'b11;
    #1;
    chk("grant_bp", int'(req_ready), 2);
    sb_q.push_back({1'b1, 8'd66});
    wait_rsp();
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("hold_rsp_valid", int'(rsp_valid), 1);
      chk("hold_rsp_p", int'(rsp_p), 66);
      chk("hold_rsp_id", int'(rsp_id), 1);
      chk("hold_req_ready", int'(req_ready), 0);
    end
    rsp_ready = 1'b1;
    req_valid = 2'b00;
    @(posedge clk); #1;
    chk("bp_released_idle", int'(busy), 0);

    // Reset during CALC drops the operation
    req_m0 = 4'd3; req_q0 = 4'd5;
    req_valid = 2'b01;
    #1;
    chk("grant_pre_abort", int'(req_ready), 1);
    @(posedge clk); #1;
    chk("busy_in_calc", int'(busy), 1);
    rst_n = 1'b0;
    req_valid = 2'b00;
    #1;
    chk("abort_req_ready", int'(req_ready), 0);
    chk("abort_rsp_valid", int'(rsp_valid), 0);
    chk("abort_rsp_id", int'(rsp_id), 0);
    chk("abort_rsp_p", int'(rsp_p), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_op_count", int'(op_count), 0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("no_rsp_after_abort", int'(rsp_valid), 0);
    end
    chk("op_count_after_abort", int'(op_count), 0);

    // Counter wrap with CNT_W=2: 1,2,3,0,1
    req_m0 = 4'd4; req_q0 = 4'd12; req_m1 = 4'd2; req_q1 = 4'd7;
    for (int i = 0; i < 5; i++) begin
      if (i % 2 == 0) run_op(2'b01, 2'b01, 1'b0, 8'd48);
      else            run_op(2'b10, 2'b10, 1'b1, 8'd14);
      chk("op_count_seq", int'(op_count), seq[i]);
    end

    // Zero operand and 9*9 on requester 1
    req_m0 = 4'd0; req_q0 = 4'd15;
    run_op(2'b01, 2'b01, 1'b0, 8'd0);
    req_m1 = 4'd9; req_q1 = 4'd9;
    run_op(2'b10, 2'b10, 1'b1, 8'd81);
    req_valid = 2'b00;

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_empty", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
